// File: rtl/wb_arbiter_rr_if.sv
// rtl/wb_arbiter_rr_if.sv - bundled master-side and slave-side Wishbone signals around the arbiter
interface wb_arbiter_rr_if #(
  parameter int NMASTERS = 4,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32
);
  logic [NMASTERS-1:0]          cyc_i;
  logic [NMASTERS-1:0]          stb_i;
  logic [NMASTERS-1:0]          we_i;
  logic [NMASTERS*DWIDTH/8-1:0] sel_i;
  logic [NMASTERS*AWIDTH-1:0]   adr_i;
  logic [NMASTERS*DWIDTH-1:0]   m_dat_i;
  logic [DWIDTH-1:0]            m_dat_o;
  logic [NMASTERS-1:0]          ack_o;
  logic [NMASTERS-1:0]          stall_o;
  logic [NMASTERS-1:0]          gnt_o;
  logic                         cyc_o;
  logic                         stb_o;
  logic                         we_o;
  logic [AWIDTH-1:0]            adr_o;
  logic [DWIDTH/8-1:0]          sel_o;
  logic [DWIDTH-1:0]            s_dat_o;
  logic [DWIDTH-1:0]            s_dat_i;
  logic                         ack_i;
  logic                         stall_i;

  // The arbiter is the slave of the N masters and drives the shared slave bus.
  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, m_dat_i, s_dat_i, ack_i, stall_i,
    output m_dat_o, ack_o, stall_o, gnt_o, cyc_o, stb_o, we_o, adr_o, sel_o, s_dat_o
  );

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, m_dat_i, s_dat_i, ack_i, stall_i,
    input  m_dat_o, ack_o, stall_o, gnt_o, cyc_o, stb_o, we_o, adr_o, sel_o, s_dat_o
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - N-master to 1-slave pipelined Wishbone arbiter, round-robin or fixed priority
module wb_arbiter_rr #(
  parameter int NMASTERS = 4,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int RR_MODE  = 1,
  parameter int MAXOUT   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_arbiter_rr_if.slave   bus
);
  localparam int IW = $clog2(NMASTERS);
  localparam int CW = $clog2(MAXOUT + 1);
  localparam int SW = DWIDTH / 8;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t              state, state_nxt;
  logic [NMASTERS-1:0] gnt, gnt_nxt;
  logic [IW-1:0]       owner, owner_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [CW-1:0]       count, count_nxt;

  logic [NMASTERS-1:0] arb_req;
  logic                win_any;
  logic [IW-1:0]       win_idx;
  logic                accept;
  logic                ack_ok;
  logic                count_nz;
  logic                count_full;

  // A releasing owner is excluded so the next grant goes to someone else.
  assign arb_req = (state == ST_OWN) ? (bus.cyc_i & ~gnt) : bus.cyc_i;

  always_comb begin
    int j;
    j       = 0;
    win_any = 1'b0;
    win_idx = '0;
    if (RR_MODE != 0) begin
      for (int i = 1; i <= NMASTERS; i++) begin
        j = (int'(ptr) + i) % NMASTERS;
        if (!win_any && arb_req[IW'(j)]) begin
          win_any = 1'b1;
          win_idx = IW'(j);
        end
      end
    end else begin
      for (int i = NMASTERS - 1; i >= 0; i--) begin
        if (arb_req[IW'(i)]) begin
          win_any = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
  end

  assign count_nz   = (count != '0);
  assign count_full = (count == CW'(MAXOUT));

  always_comb begin
    bus.cyc_o   = 1'b0;
    bus.stb_o   = 1'b0;
    bus.we_o    = 1'b0;
    bus.adr_o   = '0;
    bus.sel_o   = '0;
    bus.s_dat_o = '0;
    bus.ack_o   = '0;
    bus.stall_o = bus.cyc_i;
    if (state == ST_OWN) begin
      bus.cyc_o          = bus.cyc_i[owner];
      bus.stb_o          = bus.cyc_i[owner] & bus.stb_i[owner] & ~count_full;
      bus.we_o           = bus.we_i[owner];
      bus.adr_o          = bus.adr_i[owner*AWIDTH +: AWIDTH];
      bus.sel_o          = bus.sel_i[owner*SW +: SW];
      bus.s_dat_o        = bus.m_dat_i[owner*DWIDTH +: DWIDTH];
      bus.ack_o[owner]   = bus.ack_i & count_nz;
      bus.stall_o[owner] = bus.stall_i | count_full;
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt;

  // Acks with nothing outstanding are strays and never touch the counter.
  assign accept = bus.stb_o & ~bus.stall_i;
  assign ack_ok = (state == ST_OWN) & bus.ack_i & count_nz;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (win_any) begin
          state_nxt = ST_OWN;
          gnt_nxt   = NMASTERS'(1) << win_idx;
          owner_nxt = win_idx;
          ptr_nxt   = win_idx;
        end
      end
      ST_OWN: begin
        if (!bus.cyc_i[owner]) begin
          // Release or abort: outstanding work is forgotten, late acks get dropped.
          count_nxt = '0;
          if (win_any) begin
            gnt_nxt   = NMASTERS'(1) << win_idx;
            owner_nxt = win_idx;
            ptr_nxt   = win_idx;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
          end
        end else if (accept && !ack_ok) begin
          count_nxt = count + CW'(1);
        end else if (!accept && ack_ok) begin
          count_nxt = count - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= IW'(NMASTERS - 1);
      count <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      count <= count_nxt;
    end
  end
endmodule
